// File: rtl/qtree_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : qtree_run_sequencer_if
// Desc     : Host stream, loader and DUT source/sink channels of one run.
// Revision : 1.0 - initial release
// ============================================================================
interface qtree_run_sequencer_if #(
    parameter int N_ARGS = 2,
    parameter int PTR_W  = 16,
    parameter int RES_W  = 32
);
    logic                    s_tvalid;
    logic                    s_tlast;
    logic                    s_tready_in;
    logic                    s_tready;
    logic [PTR_W-1:0]        ptr_top;
    logic                    go_d;
    logic                    go_r;
    logic [N_ARGS*PTR_W-1:0] arg_d;
    logic [N_ARGS-1:0]       arg_r;
    logic [RES_W-1:0]        res_d;
    logic                    res_r;

    // master: the sequencer; slave: host stream, loader and benchmark DUT
    modport master (
        input  s_tvalid, s_tlast, s_tready_in, ptr_top, go_r, arg_r, res_d,
        output s_tready, go_d, arg_d, res_r
    );

    modport slave (
        output s_tvalid, s_tlast, s_tready_in, ptr_top, go_r, arg_r, res_d,
        input  s_tready, go_d, arg_d, res_r
    );
endinterface
`default_nettype wire

// File: rtl/qtree_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qtree_run_sequencer
// Desc     : Per-run controller: clears the QTree loader, admits N_ARGS trees,
//            fires Go plus pointer tokens, captures result and cycle count.
//            Watchdog enabled by defining QTREE_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qtree_run_sequencer #(
    parameter int N_ARGS  = 2,
    parameter int PTR_W   = 16,
    parameter int RES_W   = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 2**20
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  loader_clr,
    qtree_run_sequencer_if.master bus,
    output logic [RES_W-1:0]      result_data,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam int c_AW = $clog2(N_ARGS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GO   = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_TMO  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_loader_clr;
    logic              r_go_d;
    logic              r_go_done;
    logic              r_res_r;
    logic [N_ARGS-1:0] r_arg_vld;
    logic [N_ARGS-1:0] r_arg_done;
    logic [c_AW-1:0]   r_arg_cnt;
    logic [PTR_W-1:1]  r_arg_ptr [N_ARGS];
    logic [RES_W-1:0]  r_result;
    logic [CNT_W-1:0]  r_cycle_cnt;

    logic              w_start_ok;
    logic              w_tlast_hs;
    logic              w_load_fin;
    logic              w_go_fin;
    logic [N_ARGS-1:0] w_arg_fin;
    logic              w_all_fin;
    logic              w_res_hs;
    logic              w_tmo_hit;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_start_ok  = start & (r_state inside {S_IDLE, S_DONE, S_TMO});
    assign bus.s_tready = bus.s_tready_in & (r_state == S_LOAD);
    assign w_tlast_hs  = bus.s_tvalid & bus.s_tready & bus.s_tlast;
    assign w_load_fin  = w_tlast_hs & (r_arg_cnt == c_AW'(N_ARGS - 1));

    // A token counts as finished if already done or handshaking this cycle
    assign w_go_fin  = r_go_done | (r_go_d & bus.go_r);
    assign w_arg_fin = r_arg_done | (r_arg_vld & bus.arg_r);
    assign w_all_fin = w_go_fin & (&w_arg_fin);

    assign w_res_hs  = (r_state == S_RUN) & r_res_r & bus.res_d[0];
    assign w_cnt_inc = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 1'b1;

`ifdef QTREE_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_TMO_LIMIT = CNT_W'(TIMEOUT);

    // Compare the post-increment count so the count stops exactly at the limit
    assign w_tmo_hit = (w_cnt_inc >= c_TMO_LIMIT);
    assign timeout   = (r_state == S_TMO);
`else
    assign w_tmo_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TMO: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_load_fin) w_state_nxt = S_GO;
            end
            S_GO: begin
                if (w_tmo_hit)      w_state_nxt = S_TMO;
                else if (w_all_fin) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // A result landing on the limit cycle takes priority
                if (w_res_hs)       w_state_nxt = S_DONE;
                else if (w_tmo_hit) w_state_nxt = S_TMO;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_loader_clr <= 1'b0;
            r_go_d       <= 1'b0;
            r_go_done    <= 1'b0;
            r_res_r      <= 1'b0;
            r_arg_vld    <= '0;
            r_arg_done   <= '0;
            r_arg_cnt    <= '0;
            r_result     <= '0;
            r_cycle_cnt  <= '0;
            for (int i = 0; i < N_ARGS; i++) r_arg_ptr[i] <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_loader_clr <= w_start_ok;
            case (r_state)
                S_IDLE, S_DONE, S_TMO: begin
                    if (w_start_ok) begin
                        r_arg_cnt   <= '0;
                        r_arg_vld   <= '0;
                        r_arg_done  <= '0;
                        r_go_d      <= 1'b0;
                        r_go_done   <= 1'b0;
                        r_res_r     <= 1'b0;
                        r_result    <= '0;
                        r_cycle_cnt <= '0;
                        for (int i = 0; i < N_ARGS; i++) r_arg_ptr[i] <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_tlast_hs) begin
                        for (int i = 0; i < N_ARGS; i++) begin
                            if (r_arg_cnt == c_AW'(i)) r_arg_ptr[i] <= bus.ptr_top[PTR_W-1:1];
                        end
                        r_arg_cnt <= r_arg_cnt + 1'b1;
                    end
                    if (w_load_fin) begin
                        r_go_d      <= 1'b1;
                        r_arg_vld   <= '1;
                        r_go_done   <= 1'b0;
                        r_arg_done  <= '0;
                        r_cycle_cnt <= '0;
                    end
                end
                S_GO: begin
                    r_cycle_cnt <= w_cnt_inc;
                    r_go_d      <= r_go_d & ~bus.go_r;
                    r_go_done   <= w_go_fin;
                    r_arg_vld   <= r_arg_vld & ~bus.arg_r;
                    r_arg_done  <= w_arg_fin;
                    if (w_state_nxt == S_RUN) r_res_r <= 1'b1;
                    if (w_state_nxt == S_TMO) begin
                        r_go_d    <= 1'b0;
                        r_arg_vld <= '0;
                    end
                end
                S_RUN: begin
                    r_cycle_cnt <= w_cnt_inc;
                    if (w_res_hs) begin
                        r_result <= bus.res_d;
                        r_res_r  <= 1'b0;
                    end else if (w_state_nxt == S_TMO) begin
                        r_res_r  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointer payload is kept without bit0; bit0 carries the token valid
    for (genvar gi = 0; gi < N_ARGS; gi++) begin : g_arg_pack
        assign bus.arg_d[gi*PTR_W +: PTR_W] = {r_arg_ptr[gi], r_arg_vld[gi]};
    end

    assign busy        = r_state inside {S_LOAD, S_GO, S_RUN};
    assign done        = (r_state == S_DONE);
    assign loader_clr  = r_loader_clr;
    assign bus.go_d    = r_go_d;
    assign bus.res_r   = r_res_r;
    assign result_data = r_result;
    assign cycle_count = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_qtree_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qtree_run_sequencer
// Desc     : Directed and randomized runs checked against an offset-based
//            model of one run (token drop, RUN entry, result, count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qtree_run_sequencer;

    localparam int N_ARGS  = 2;
    localparam int PTR_W   = 16;
    localparam int RES_W   = 32;
    localparam int CNT_W   = 32;
    localparam int TMO_LIM = 64;
    localparam int NEVER   = 1 << 30;
`ifdef QTREE_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic             clk;
    logic             aresetn;
    logic             start;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             loader_clr;
    logic [RES_W-1:0] result_data;
    logic [CNT_W-1:0] cycle_count;

    qtree_run_sequencer_if #(.N_ARGS(N_ARGS), .PTR_W(PTR_W), .RES_W(RES_W)) bus ();

    qtree_run_sequencer #(
        .N_ARGS (N_ARGS),
        .PTR_W  (PTR_W),
        .RES_W  (RES_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TMO_LIM)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .loader_clr (loader_clr),
        .bus        (bus),
        .result_data(result_data),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Scenario of one run; offsets are cycles counted from the first GO cycle
    int               m_nb  [N_ARGS];
    logic [PTR_W-1:0] m_ptr [N_ARGS];
    int               m_a   [N_ARGS];
    int               m_g;
    int               m_res_at;
    logic [RES_W-1:0] m_rv;
    bit               m_extra;
    bit               m_poke;
    int               m_stop;
    int               m_exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_ARGS*PTR_W-1:0] pack(input logic [N_ARGS-1:0] v);
        logic [N_ARGS*PTR_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_ARGS; i++) p[i*PTR_W +: PTR_W] = {m_ptr[i][PTR_W-1:1], v[i]};
        return p;
    endfunction

    task automatic idle_inputs();
        start           = 1'b0;
        bus.s_tvalid    = 1'b0;
        bus.s_tlast     = 1'b0;
        bus.s_tready_in = 1'b1;
        bus.ptr_top     = '0;
        bus.go_r        = 1'b0;
        bus.arg_r       = '0;
        bus.res_d       = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_loader_clr"}, loader_clr, 0);
        chk({tag, "_go_d"}, bus.go_d, 0);
        chk({tag, "_arg_d"}, bus.arg_d, 0);
        chk({tag, "_res_r"}, bus.res_r, 0);
        chk({tag, "_result"}, result_data, 0);
        chk({tag, "_count"}, cycle_count, 0);
        chk({tag, "_s_tready"}, bus.s_tready, 0);
    endtask

    // Called just after the edge that accepted start: first LOAD cycle
    task automatic first_load_checks();
        start = 1'b0;
        @(negedge clk);
        chk("start_loader_clr", loader_clr, 1);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_timeout", timeout, 0);
        chk("start_result", result_data, 0);
        chk("start_count", cycle_count, 0);
        chk("start_arg_d", bus.arg_d, 0);
        chk("start_go_d", bus.go_d, 0);
        chk("start_res_r", bus.res_r, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        idle_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        first_load_checks();
    endtask

    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        idle_inputs();
        aresetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_trees();
        int tree;
        int beat;
        int guard;
        logic v;
        logic r;
        logic l;
        tree  = 0;
        beat  = 0;
        guard = 0;
        while (tree < N_ARGS && guard < 400) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            l = (beat == m_nb[tree] - 1);
            bus.s_tvalid    = v;
            bus.s_tready_in = r;
            bus.s_tlast     = l;
            bus.ptr_top     = l ? m_ptr[tree] : PTR_W'($urandom);
            @(negedge clk);
            chk("load_s_tready", bus.s_tready, r);
            chk("load_busy", busy, 1);
            chk("load_loader_clr", loader_clr, 0);
            @(posedge clk); #1;
            if (v && r) begin
                if (l) begin
                    tree++;
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            guard++;
        end
        if (tree < N_ARGS) begin
            n_chk++;
            n_err++;
            $error("FAIL load_budget observed=%0d expected=%0d", tree, N_ARGS);
        end
    endtask

    task automatic go_phase();
        int run_start;
        int t_end;
        bit to_done;
        bit to_tmo;
        logic [N_ARGS-1:0] v;
        run_start = m_g;
        for (int i = 0; i < N_ARGS; i++) if (m_a[i] > run_start) run_start = m_a[i];
        run_start = run_start + 1;
        to_done = (m_res_at < NEVER);
        t_end   = ((m_res_at > run_start) ? m_res_at : run_start) + 1;
        to_tmo  = 1'b0;
        if (TMO_EN && (!to_done || t_end > TMO_LIM)) begin
            to_tmo  = 1'b1;
            to_done = 1'b0;
            t_end   = TMO_LIM;
        end
        if (m_stop >= 0 && (!(to_done || to_tmo) || m_stop < t_end)) begin
            to_done = 1'b0;
            to_tmo  = 1'b0;
            t_end   = m_stop;
        end
        for (int k = 0; k < t_end; k++) begin
            start           = m_poke && (k == 1);
            bus.s_tvalid    = m_extra;
            bus.s_tlast     = 1'b1;
            bus.s_tready_in = 1'b1;
            bus.ptr_top     = PTR_W'($urandom);
            bus.go_r        = (k >= m_g);
            for (int i = 0; i < N_ARGS; i++) bus.arg_r[i] = (k >= m_a[i]);
            bus.res_d = (k >= m_res_at) ? m_rv : (RES_W'($urandom) & ~RES_W'(1));
            for (int i = 0; i < N_ARGS; i++) v[i] = (k <= m_a[i]);
            @(negedge clk);
            chk("go_go_d", bus.go_d, (k <= m_g));
            chk("go_arg_d", bus.arg_d, pack(v));
            chk("go_res_r", bus.res_r, (k >= run_start));
            chk("go_count", cycle_count, k);
            chk("go_busy", busy, 1);
            chk("go_done", done, 0);
            chk("go_s_tready", bus.s_tready, 0);
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        if (to_done) begin
            m_exp_cnt = t_end;
            chk("end_done", done, 1);
            chk("end_timeout", timeout, 0);
            chk("end_busy", busy, 0);
            chk("end_res_r", bus.res_r, 0);
            chk("end_go_d", bus.go_d, 0);
            chk("end_arg_d", bus.arg_d, pack('0));
            chk("end_result", result_data, m_rv);
            chk("end_count", cycle_count, t_end);
        end else if (to_tmo) begin
            m_exp_cnt = TMO_LIM;
            chk("tmo_timeout", timeout, 1);
            chk("tmo_done", done, 0);
            chk("tmo_busy", busy, 0);
            chk("tmo_res_r", bus.res_r, 0);
            chk("tmo_go_d", bus.go_d, 0);
            chk("tmo_arg_d", bus.arg_d, pack('0));
            chk("tmo_result", result_data, 0);
            chk("tmo_count", cycle_count, TMO_LIM);
        end else begin
            chk("stop_busy", busy, 1);
            chk("stop_done", done, 0);
            chk("stop_timeout", timeout, 0);
            chk("stop_count", cycle_count, t_end);
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < N_ARGS; i++) begin
            m_nb[i]  = $urandom_range(1, 4);
            m_ptr[i] = PTR_W'($urandom) | PTR_W'(1);
            m_a[i]   = $urandom_range(0, 8);
        end
        m_g      = $urandom_range(0, 8);
        m_res_at = $urandom_range(0, 20);
        m_rv     = RES_W'($urandom) | RES_W'(1);
        m_extra  = $urandom_range(0, 1);
        m_poke   = $urandom_range(0, 1);
        m_stop   = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with start held high
        idle_inputs();
        aresetn = 1'b0;
        start   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        aresetn = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_loader_clr", loader_clr, 0);
        @(posedge clk); #1;
        first_load_checks();

        // Directed run: trees of 5 and 1 beats, staggered readies, late result
        m_nb[0] = 5; m_nb[1] = 1;
        m_ptr[0] = 16'h0013; m_ptr[1] = 16'h0025;
        m_g = 0; m_a[0] = 3; m_a[1] = 7;
        m_res_at = 8 + 10;
        m_rv = 32'h0000_0055;
        m_extra = 1'b1; m_poke = 1'b1; m_stop = -1;
        load_trees();
        go_phase();
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_hold", done, 1);
        chk("done_count_frozen", cycle_count, m_exp_cnt);

        // Randomized runs, each restarted from DONE
        for (int r = 0; r < 6; r++) begin
            set_random();
            do_start();
            load_trees();
            go_phase();
        end

        // Result on the exact watchdog-limit cycle
        set_random();
        m_g = 0; m_a[0] = 0; m_a[1] = 0;
        m_res_at = TMO_LIM - 1;
        do_start();
        load_trees();
        go_phase();

        // Result never arrives: watchdog fires, or the run waits indefinitely
        set_random();
        m_g = 0; m_a[0] = 1; m_a[1] = 2;
        m_res_at = NEVER; m_poke = 1'b0; m_stop = 1000;
        do_start();
        load_trees();
        go_phase();
        do_reset("rst_after_long");

        // Abort in GO with tokens still pending
        set_random();
        m_g = 2; m_a[0] = 6; m_a[1] = 3;
        m_res_at = NEVER; m_stop = 5;
        do_start();
        load_trees();
        go_phase();
        do_reset("rst_mid_run");

        // Clean run after the abort
        set_random();
        do_start();
        load_trees();
        go_phase();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
